// File: rtl/hazard_forwarding_unit.sv
// Hazard and forwarding control for a single-issue pipeline: detects load-use
// stalls and registers EX/MEM bypass selections for the instruction entering execute.
module hazard_forwarding_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_write,
  input  logic        issue_is_load,
  input  logic        issue_use_imm,
  input  logic        flush,
  input  logic [31:0] ex_result,
  input  logic [31:0] mem_load_data,
  output logic        stall,
  output logic        mux1_select,
  output logic [1:0]  mux2_select,
  output logic [31:0] Forward_rs1,
  output logic [31:0] Forward_rs2,
  output logic        ex_valid
);

  logic        exValid_q, exWrite_q, exIsLoad_q;
  logic [4:0]  exRd_q;
  logic        memValid_q, memWrite_q, memIsLoad_q;
  logic [4:0]  memRd_q;
  logic [31:0] memData_q;

  logic        mux1_q, mux1_d;
  logic [1:0]  mux2_q, mux2_d;
  logic [31:0] fwd1_q, fwd1_d;
  logic [31:0] fwd2_q, fwd2_d;

  logic        loadUse, accept;
  logic        rs1FromEx, rs1FromMem, rs2FromEx, rs2FromMem;
  logic [31:0] memValue;

  function automatic logic producerMatch(input logic valid, input logic write,
                                         input logic [4:0] rd, input logic [4:0] src);
    return valid & write & (rd != 5'd0) & (rd == src);
  endfunction

  // The WB stage is never a bypass source: the register file already returns
  // written data, so only EX and MEM producers are tracked here.
  assign memValue   = memIsLoad_q ? mem_load_data : memData_q;
  assign rs1FromEx  = producerMatch(exValid_q, exWrite_q, exRd_q, issue_rs1) & ~exIsLoad_q;
  assign rs2FromEx  = producerMatch(exValid_q, exWrite_q, exRd_q, issue_rs2) & ~exIsLoad_q;
  assign rs1FromMem = producerMatch(memValid_q, memWrite_q, memRd_q, issue_rs1);
  assign rs2FromMem = producerMatch(memValid_q, memWrite_q, memRd_q, issue_rs2);

  assign loadUse = issue_valid & ~flush & exValid_q & exIsLoad_q & exWrite_q
                 & (exRd_q != 5'd0)
                 & ((exRd_q == issue_rs1) | ((exRd_q == issue_rs2) & ~issue_use_imm));
  assign accept  = issue_valid & ~loadUse & ~flush;
  assign stall   = loadUse;

  // Bypass selection for the instruction about to enter execute; the younger
  // EX producer takes precedence over the MEM producer.
  always_comb begin
    mux1_d = 1'b0;
    mux2_d = 2'b00;
    fwd1_d = 32'd0;
    fwd2_d = 32'd0;
    if (accept) begin
      if (rs1FromEx) begin
        mux1_d = 1'b1;
        fwd1_d = ex_result;
      end else if (rs1FromMem) begin
        mux1_d = 1'b1;
        fwd1_d = memValue;
      end
      if (issue_use_imm) begin
        mux2_d = 2'b10;
      end else if (rs2FromEx) begin
        mux2_d = 2'b01;
        fwd2_d = ex_result;
      end else if (rs2FromMem) begin
        mux2_d = 2'b01;
        fwd2_d = memValue;
      end
    end
  end

  // Pipeline records advance every cycle; a flush squashes the instruction
  // leaving EX so it reaches MEM as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      exValid_q   <= 1'b0;
      exWrite_q   <= 1'b0;
      exIsLoad_q  <= 1'b0;
      exRd_q      <= 5'd0;
      memValid_q  <= 1'b0;
      memWrite_q  <= 1'b0;
      memIsLoad_q <= 1'b0;
      memRd_q     <= 5'd0;
      memData_q   <= 32'd0;
      mux1_q      <= 1'b0;
      mux2_q      <= 2'b00;
      fwd1_q      <= 32'd0;
      fwd2_q      <= 32'd0;
    end else begin
      exValid_q   <= accept;
      exWrite_q   <= issue_write;
      exIsLoad_q  <= issue_is_load;
      exRd_q      <= issue_rd;
      memValid_q  <= exValid_q & ~flush;
      memWrite_q  <= exWrite_q;
      memIsLoad_q <= exIsLoad_q;
      memRd_q     <= exRd_q;
      memData_q   <= ex_result;
      mux1_q      <= mux1_d;
      mux2_q      <= mux2_d;
      fwd1_q      <= fwd1_d;
      fwd2_q      <= fwd2_d;
    end
  end

  assign mux1_select = mux1_q;
  assign mux2_select = mux2_q;
  assign Forward_rs1 = fwd1_q;
  assign Forward_rs2 = fwd2_q;
  assign ex_valid    = exValid_q;

endmodule

// File: tb/tb_hazard_forwarding_unit.sv
// Bench for hazard_forwarding_unit: directed vector table for the pipeline
// corner cases, then random traffic against a cycle-history reference model.
module tb_hazard_forwarding_unit;

  localparam int MAXC     = 2048;
  localparam int NUM_VEC  = 20;
  localparam int NUM_RAND = 900;

  logic        clk;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic        issue_write, issue_is_load, issue_use_imm;
  logic        flush;
  logic [31:0] ex_result, mem_load_data;
  logic        stall;
  logic        mux1_select;
  logic [1:0]  mux2_select;
  logic [31:0] Forward_rs1, Forward_rs2;
  logic        ex_valid;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic        rst, fl, iv;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, ld, imm;
    logic [31:0] exr, mld;
    logic        chk;
    logic        eStall, eM1;
    logic [1:0]  eM2;
    logic [31:0] eF1, eF2;
    logic        eExv;
  } vec_t;

  vec_t vecs [NUM_VEC];

  // Per-cycle history of everything driven; instruction issued in cycle t
  // sits in EX during t+1 and in MEM during t+2.
  logic        hRst [MAXC], hFl [MAXC], hIv [MAXC], hWr [MAXC];
  logic        hLd [MAXC], hImm [MAXC], hAcc [MAXC];
  logic [4:0]  hRs1 [MAXC], hRs2 [MAXC], hRd [MAXC];
  logic [31:0] hExr [MAXC], hMld [MAXC];

  hazard_forwarding_unit dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_rd      (issue_rd),
    .issue_write   (issue_write),
    .issue_is_load (issue_is_load),
    .issue_use_imm (issue_use_imm),
    .flush         (flush),
    .ex_result     (ex_result),
    .mem_load_data (mem_load_data),
    .stall         (stall),
    .mux1_select   (mux1_select),
    .mux2_select   (mux2_select),
    .Forward_rs1   (Forward_rs1),
    .Forward_rs2   (Forward_rs2),
    .ex_valid      (ex_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mkVec(input int rst, input int fl, input int iv,
                                 input int rs1, input int rs2, input int rd,
                                 input int wr, input int ld, input int imm,
                                 input logic [31:0] exr, input logic [31:0] mld,
                                 input int chk, input int st, input int m1, input int m2,
                                 input logic [31:0] f1, input logic [31:0] f2, input int exv);
    vec_t v;
    v.rst = rst[0];  v.fl = fl[0];  v.iv = iv[0];
    v.rs1 = rs1[4:0]; v.rs2 = rs2[4:0]; v.rd = rd[4:0];
    v.wr = wr[0];  v.ld = ld[0];  v.imm = imm[0];
    v.exr = exr;  v.mld = mld;
    v.chk = chk[0];  v.eStall = st[0];  v.eM1 = m1[0];  v.eM2 = m2[1:0];
    v.eF1 = f1;  v.eF2 = f2;  v.eExv = exv[0];
    return v;
  endfunction

  // True when the instruction issued in cycle t was accepted and writes s.
  function automatic logic writesReg(input int t, input logic [4:0] s);
    if (t < 0) return 1'b0;
    return hAcc[t] && hWr[t] && (hRd[t] != 5'd0) && (hRd[t] == s);
  endfunction

  // Youngest live producer of s visible to an issue in cycle c.
  task automatic bypassFor(input int c, input logic [4:0] s,
                           output logic hit, output logic [31:0] val);
    hit = 1'b0;
    val = 32'd0;
    if (writesReg(c - 1, s) && !hLd[c - 1]) begin
      hit = 1'b1;
      val = hExr[c];
    end else if (writesReg(c - 2, s) && !hFl[c - 1] && !hRst[c - 1]) begin
      hit = 1'b1;
      val = hLd[c - 2] ? hMld[c] : hExr[c - 1];
    end
  endtask

  task automatic modelCycle(input int c, output logic mSt, output logic mM1,
                            output logic [1:0] mM2, output logic [31:0] mF1,
                            output logic [31:0] mF2, output logic mExv);
    logic h1, h2;
    logic [31:0] v1, v2;
    mSt = hIv[c] && !hFl[c] && (c >= 1) &&
          (writesReg(c - 1, hRs1[c]) || (writesReg(c - 1, hRs2[c]) && !hImm[c])) &&
          hLd[c - 1];
    hAcc[c] = hIv[c] && !hFl[c] && !mSt && !hRst[c];
    bypassFor(c, hRs1[c], h1, v1);
    bypassFor(c, hRs2[c], h2, v2);
    mM1 = 1'b0; mM2 = 2'b00; mF1 = 32'd0; mF2 = 32'd0;
    mExv = hAcc[c];
    if (hAcc[c]) begin
      mM1 = h1;
      mF1 = v1;
      if (hImm[c]) mM2 = 2'b10;
      else begin
        mM2 = h2 ? 2'b01 : 2'b00;
        mF2 = v2;
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    reset         = v.rst;
    flush         = v.fl;
    issue_valid   = v.iv;
    issue_rs1     = v.rs1;
    issue_rs2     = v.rs2;
    issue_rd      = v.rd;
    issue_write   = v.wr;
    issue_is_load = v.ld;
    issue_use_imm = v.imm;
    ex_result     = v.exr;
    mem_load_data = v.mld;
    hRst[cyc] = v.rst;  hFl[cyc] = v.fl;  hIv[cyc] = v.iv;
    hRs1[cyc] = v.rs1;  hRs2[cyc] = v.rs2; hRd[cyc] = v.rd;
    hWr[cyc] = v.wr;    hLd[cyc] = v.ld;   hImm[cyc] = v.imm;
    hExr[cyc] = v.exr;  hMld[cyc] = v.mld;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Drive on the falling edge, check stall just after, then check the
  // registered outputs 1 time unit past the next rising edge.
  task automatic runCycle(input vec_t v, input logic useModel);
    logic mSt, mM1, mExv, eSt, eM1, eExv, chk;
    logic [1:0] mM2, eM2;
    logic [31:0] mF1, mF2, eF1, eF2;
    applyStimulus(v);
    modelCycle(cyc, mSt, mM1, mM2, mF1, mF2, mExv);
    if (useModel) begin
      chk = 1'b1; eSt = mSt; eM1 = mM1; eM2 = mM2; eF1 = mF1; eF2 = mF2; eExv = mExv;
    end else begin
      chk = v.chk; eSt = v.eStall; eM1 = v.eM1; eM2 = v.eM2;
      eF1 = v.eF1; eF2 = v.eF2; eExv = v.eExv;
    end
    #1;
    if (chk) checkOutput("stall", {31'd0, stall}, {31'd0, eSt});
    @(posedge clk);
    #1;
    checkOutput("mux1_select", {31'd0, mux1_select}, {31'd0, eM1});
    checkOutput("mux2_select", {30'd0, mux2_select}, {30'd0, eM2});
    checkOutput("Forward_rs1", Forward_rs1, eF1);
    checkOutput("Forward_rs2", Forward_rs2, eF2);
    checkOutput("ex_valid", {31'd0, ex_valid}, {31'd0, eExv});
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    //             rst fl iv rs1 rs2 rd wr ld imm  exr            mld           chk st m1 m2  f1             f2       exv
    vecs[0]  = mkVec(1, 0, 0,  0,  0,  0, 0, 0, 0, 32'h0,         32'h0,          0, 0, 0, 0, 32'h0,         32'h0,   0);
    vecs[1]  = mkVec(1, 0, 0,  0,  0,  0, 0, 0, 0, 32'h0,         32'h0,          1, 0, 0, 0, 32'h0,         32'h0,   0);
    vecs[2]  = mkVec(0, 0, 1,  0,  0,  5, 1, 0, 0, 32'h0,         32'h0,          1, 0, 0, 0, 32'h0,         32'h0,   1);
    vecs[3]  = mkVec(0, 0, 1,  5,  0,  5, 1, 0, 0, 32'h10,        32'h0,          1, 0, 1, 0, 32'h10,        32'h0,   1);
    vecs[4]  = mkVec(0, 0, 1,  0,  5,  7, 1, 0, 0, 32'h20,        32'h0,          1, 0, 0, 1, 32'h0,         32'h20,  1);
    vecs[5]  = mkVec(0, 0, 1,  7,  5,  8, 1, 0, 0, 32'h99,        32'h0,          1, 0, 1, 1, 32'h99,        32'h20,  1);
    vecs[6]  = mkVec(0, 0, 1,  0,  0,  0, 1, 0, 0, 32'h55,        32'h0,          1, 0, 0, 0, 32'h0,         32'h0,   1);
    vecs[7]  = mkVec(0, 0, 1,  0,  9, 10, 1, 0, 0, 32'h1234,      32'h0,          1, 0, 0, 0, 32'h0,         32'h0,   1);
    vecs[8]  = mkVec(0, 0, 1,  1,  2,  6, 1, 1, 0, 32'h77,        32'h0,          1, 0, 0, 0, 32'h0,         32'h0,   1);
    vecs[9]  = mkVec(0, 0, 1,  6,  3, 11, 1, 0, 0, 32'hAAAA,      32'h0,          1, 1, 0, 0, 32'h0,         32'h0,   0);
    vecs[10] = mkVec(0, 0, 1,  6,  3, 11, 1, 0, 0, 32'hBBBB,      32'hDEADBEEF,   1, 0, 1, 0, 32'hDEADBEEF,  32'h0,   1);
    vecs[11] = mkVec(0, 0, 1,  0,  0,  6, 1, 1, 1, 32'h11,        32'h0,          1, 0, 0, 2, 32'h0,         32'h0,   1);
    vecs[12] = mkVec(0, 0, 1, 11,  6, 12, 1, 0, 1, 32'h3,         32'h0,          1, 0, 1, 2, 32'h11,        32'h0,   1);
    vecs[13] = mkVec(0, 0, 1,  6, 12, 13, 1, 0, 1, 32'h44,        32'h66,         1, 0, 1, 2, 32'h66,        32'h0,   1);
    vecs[14] = mkVec(0, 0, 1,  0,  0,  6, 1, 1, 1, 32'h5,         32'h0,          1, 0, 0, 2, 32'h0,         32'h0,   1);
    vecs[15] = mkVec(0, 1, 1,  6,  0,  7, 1, 0, 0, 32'h6,         32'h0,          1, 0, 0, 0, 32'h0,         32'h0,   0);
    vecs[16] = mkVec(0, 0, 1,  6,  0,  6, 1, 1, 1, 32'h7,         32'hCAFE,       1, 0, 0, 2, 32'h0,         32'h0,   1);
    vecs[17] = mkVec(1, 0, 1,  6,  0,  7, 1, 0, 0, 32'h8,         32'h0,          1, 1, 0, 0, 32'h0,         32'h0,   0);
    vecs[18] = mkVec(0, 0, 1,  6,  0,  7, 1, 0, 0, 32'h9,         32'hBAD,        1, 0, 0, 0, 32'h0,         32'h0,   1);
    vecs[19] = mkVec(0, 0, 0,  0,  0,  0, 0, 0, 0, 32'h0,         32'h0,          1, 0, 0, 0, 32'h0,         32'h0,   0);

    applyStimulus(vecs[0]);
    @(negedge clk);

    $display("[TB] directed vectors");
    for (int i = 0; i < NUM_VEC; i++) runCycle(vecs[i], 1'b0);

    $display("[TB] random traffic");
    for (int i = 0; i < NUM_RAND; i++) begin
      vec_t r;
      r = mkVec((i == 0) ? 1 : int'($urandom_range(0, 31) == 0),
                int'($urandom_range(0, 9) == 0),
                int'($urandom_range(0, 4) != 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 6) != 0),
                int'($urandom_range(0, 2) == 0),
                int'($urandom_range(0, 3) == 0),
                $urandom, $urandom,
                1, 0, 0, 0, 32'h0, 32'h0, 0);
      runCycle(r, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
